window_gen3x3: RTL
==================

# window_gen3x3

Streaming 3x3 window generator that feeds the filter stage. It accepts a raster-order 8-bit pixel stream, buffers two image lines, and emits one 72-bit window per interior pixel on a valid/ready interface. The output carries the nine pixels packed top-left first, which is the bus format the median and Sobel filter stages unpack. It is the producer end of the window bus; the filter stage is the consumer.

## Interface
- IMG_W, 100, image width in pixels (>= 3)
- IMG_H, 100, image height in pixels (>= 3)
- PIX_W, 8, pixel width in bits
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- pix_in  in  PIX_W  input pixel, raster order (row-major, column 0 first)
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  block accepts pix_in this cycle
- win_out  out  9*PIX_W  window {p00,p01,p02,p10,p11,p12,p20,p21,p22}; p00 at [71:64]; row 0 is oldest (top); col 0 is leftmost
- win_valid  out  1  win_out valid; held until accepted
- win_ready  in  1  consumer accepts win_out
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

## Operation
- Accept: pix_valid && pix_ready.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) track the position of the next pixel.
  - On accept, col increments.
  - At col == IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0.
- Line buffers: lb0 holds row r-1 and lb1 holds row r-2, each IMG_W words.
  - Read is asynchronous at address col.
  - On accept: lb1[col] <= lb0[col]; lb0[col] <= pix_in.
- Window registers: three columns of three pixels.
  - On accept, the columns shift left.
  - The new right column is {lb1[col], lb0[col], pix_in} (top, middle, bottom).
- Window emission: on accept with row >= 2 and col >= 2, load win_out from the shifted registers and set win_valid.
  - The emitted window is centred on (row-1, col-1).
  - Columns 0 and 1 of every row emit nothing, so windows never straddle a row wrap.
- Window count: exactly (IMG_H-2)*(IMG_W-2) windows per frame; 9604 at the defaults.
- Output register: single entry.
  - pix_ready = !win_valid || win_ready.
  - win_valid clears on win_ready unless a new window loads in the same cycle.
- frame_done: registered, high the cycle after the last pixel of the frame is accepted. It coincides with the final window's win_valid rising.

## Timing
- Latency: win_valid rises 1 cycle after the accept of the pixel that completes the window.
- Throughput: 1 pixel per cycle while win_ready is held high.
- Backpressure:
  - With win_valid high and win_ready low: pix_ready is low, win_out is stable, nothing is lost.
  - When win_valid && win_ready coincides with an accept that completes a new window, the new window loads with no bubble.
- Reset values: win_valid 0, win_out 0, frame_done 0, pix_ready 1, counters 0. Line buffers are not cleared; gating makes stale contents unreachable.
- Reset mid-frame: the partial frame is discarded and any pending window is dropped. The next accepted pixel is (0,0).
- pix_valid low: no state change. Gaps between pixels are allowed anywhere, including across a row wrap.

## Configuration
- WINDOW_GEN_POS_EN defined:
  - Adds outputs win_row and win_col, each $clog2(IMG_H) / $clog2(IMG_W) bits wide.
  - They give the centre coordinates of win_out, are registered with win_out, and reset to 0.
- WINDOW_GEN_POS_EN undefined: these ports and their registers are absent. All other behaviour is identical.

## Structure
- Package window_pkg holds:
  - PIX_W, IMG_W, IMG_H defaults
  - WIN_W = 9*PIX_W
  - COL_W = $clog2(IMG_W), ROW_W = $clog2(IMG_H)
  - the pixel typedef
- Sub-module line_buffer: an IMG_W-deep array of PIX_W words with an asynchronous read port and a synchronous write port. Instantiated twice.

## Test plan
- Reset, then one 100x100 frame with pixel = (r*100+c) mod 256 and win_ready=1 throughout:
  - exactly 9604 windows
  - first window 72'h000102646566C8C9CA
- Row boundary, same frame: accepting pixels (3,0) and (3,1) produces no window; accepting (3,2) yields the window centred on (2,1) one cycle later.
- Drop win_ready for 5 cycles mid-row:
  - pix_ready is low for those cycles and win_out holds
  - no window is lost or duplicated; the total is still 9604
- Last window is 72'h454647A9AAAB0D0E0F, with frame_done pulsing exactly once in the same cycle. A second frame follows with no gap and produces its first window correctly.
- Assert rst after 250 pixels, then send a full frame: 9604 windows, first window equal to scenario 1's.
- With WINDOW_GEN_POS_EN: the first window reports win_row=1, win_col=1; the last reports 98, 98.

Source files
------------

// File: rtl/window_pkg.sv
// Shared types and default sizes for the 3x3 window generator.
// Imported by window_gen3x3 and its line buffers.
package window_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int DEF_IMG_W = 100;
  localparam int DEF_IMG_H = 100;

  localparam int WIN_W = 9 * DEF_PIX_W;
  localparam int COL_W = $clog2(DEF_IMG_W);
  localparam int ROW_W = $clog2(DEF_IMG_H);

  typedef logic [DEF_PIX_W-1:0] pix_t;

endpackage

// File: rtl/window_gen3x3_line_buffer.sv
// One image line of pixel storage: async read, sync write.
// Contents are never cleared; the caller gates stale reads.
module line_buffer
  import window_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = DEF_PIX_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Write the addressed word on an accepted pixel
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/window_gen3x3.sv
// Streaming 3x3 window generator: raster pixels in, packed windows out.
// Optional WINDOW_GEN_POS_EN adds win_row/win_col centre outputs.
module window_gen3x3
  import window_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [9*PIX_W-1:0]       win_out,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic                     frame_done
`ifdef WINDOW_GEN_POS_EN
  ,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int WW = 9 * PIX_W;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             acc;
  logic             last_px;
  logic             emit;

  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;

  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic [WW-1:0]    win_flat;

  logic [WW-1:0]    win_out_q, win_out_d;
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;

  assign pix_ready  = !win_valid_q || win_ready;
  assign acc        = pix_valid && pix_ready;
  assign last_px    = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign emit       = acc && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

  assign win_out    = win_out_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

  // lb0 holds the previous row, lb1 the row before it
  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb0 (
    .clk     (clk),
    .we_i    (acc),
    .addr_i  (col_q),
    .wdata_i (pix_in),
    .rdata_o (lb0_rd)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk     (clk),
    .we_i    (acc),
    .addr_i  (col_q),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  // Raster position of the next pixel, wrapping at row and frame end
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (acc) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Shift window columns left and insert the new right column
  always_comb begin
    win_d = win_q;
    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = pix_in;
    end
  end

  // Pack the shifted window top-left first into the bus format
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_flat[WW-1-(r*3+c)*PIX_W -: PIX_W] = win_d[r][c];
      end
    end
  end

  // Single-entry output register with valid/ready handshake
  always_comb begin
    win_out_d    = win_out_q;
    win_valid_d  = win_valid_q;
    frame_done_d = acc && last_px;
    if (emit) begin
      win_out_d   = win_flat;
      win_valid_d = 1'b1;
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  // Position and output state; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_out_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_out_q    <= win_out_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Window pixels need no reset: emission waits until all are fresh
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

`ifdef WINDOW_GEN_POS_EN
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;

  assign win_row = win_row_q;
  assign win_col = win_col_q;

  // Centre of the emitted window trails the completing pixel by one
  always_comb begin
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    if (emit) begin
      win_row_d = row_q - RW'(1);
      win_col_d = col_q - CW'(1);
    end
  end

  // Centre coordinates load alongside win_out
  always_ff @(posedge clk) begin
    if (rst) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
    end
  end
`endif

endmodule
